task_sequencer: RTL and testbench

TASK_SEQUENCER -- requirements
Module: task_sequencer

---
 rtl/task_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_task_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/task_sequencer.sv
// task_sequencer: runs up to NUM_TASKS sub-FSMs one after another in ascending
// index order, as selected by an enable mask captured at start. Each selected
// task gets a one-cycle start pulse. The sequencer then waits for that task's
// finish pulse, for an abort, or for an optional timeout. While a task is
// selected, its memory request is muxed onto the shared mem_* port.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start, abort        sequence control (start is sampled in IDLE only)
//   task_enable         per-task run mask, captured when start is accepted
//   task_finish         per-task done pulses; only the active task's bit counts
//   task_we/addr/wdata  per-task memory requests, task i at [i*W +: W]
//   task_start          one-cycle launch pulse to the active task
//   mem_we/addr/wdata   request of the active task; 0 when no task is selected
//   busy, active_task   status decoded from the registered state
//   done                one-cycle pulse when a sequence completes normally
//   error               sticky; set by abort or timeout, cleared by next start
module task_sequencer #(
  parameter int unsigned NUM_TASKS      = 2,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NUM_TASKS-1:0]          task_enable,
  input  logic [NUM_TASKS-1:0]          task_finish,
  input  logic [NUM_TASKS-1:0]          task_we,
  input  logic [NUM_TASKS*ADDR_W-1:0]   task_addr,
  input  logic [NUM_TASKS*DATA_W-1:0]   task_wdata,
  output logic [NUM_TASKS-1:0]          task_start,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          busy,
  output logic [2:0]                    active_task,
  output logic                          done,
  output logic                          error
);

  localparam int unsigned IDX_W   = 3;
  // Counter wide enough to hold TIMEOUT_CYCLES itself, never less than 1 bit.
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Counter value seen during the last permitted WAIT cycle.
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE,
    S_FAIL
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_TASKS-1:0]   mask_q,  mask_d;
  logic [IDX_W-1:0]       idx_q,   idx_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic                   error_q, error_d;

  logic                   sel_finish;
  logic                   task_selected;
  logic [IDX_W:0]         first_pick;
  logic [IDX_W:0]         next_pick;

  // Lowest set bit of mask at or above index 'from'; MSB of result = found.
  function automatic logic [IDX_W:0] pick_from(input logic [NUM_TASKS-1:0] mask,
                                               input int unsigned          from);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = int'(NUM_TASKS) - 1; i >= 0; i--) begin
      if ((i >= int'(from)) && mask[i]) begin
        r = {1'b1, IDX_W'(i)};
      end
    end
    return r;
  endfunction

  assign first_pick    = pick_from(task_enable, 0);
  assign next_pick     = pick_from(mask_q, 32'(idx_q) + 32'd1);
  assign task_selected = (state_q == S_LAUNCH) || (state_q == S_WAIT);

  // Finish bit of the active task only; other tasks' finish bits are ignored.
  always_comb begin
    sel_finish = 1'b0;
    for (int i = 0; i < int'(NUM_TASKS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_finish = task_finish[i];
      end
    end
  end

  // Next-state and register update logic.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    error_d = error_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = task_enable;
          error_d = 1'b0;
          if (first_pick[IDX_W]) begin
            idx_d   = first_pick[IDX_W-1:0];
            state_d = S_LAUNCH;
          end else begin
            idx_d   = '0;
            state_d = S_DONE;
          end
        end
      end

      S_LAUNCH: begin
        cnt_d = '0;
        if (abort) begin
          error_d = 1'b1;
          state_d = S_FAIL;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Priority: abort, then finish, then timeout.
        if (abort) begin
          error_d = 1'b1;
          state_d = S_FAIL;
        end else if (sel_finish) begin
          if (next_pick[IDX_W]) begin
            idx_d   = next_pick[IDX_W-1:0];
            state_d = S_LAUNCH;
          end else begin
            state_d = S_DONE;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
          error_d = 1'b1;
          state_d = S_FAIL;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  // Status outputs decoded from registered state only.
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign error       = error_q;
  assign active_task = task_selected ? idx_q : '0;
  assign task_start  = (state_q == S_LAUNCH) ? (NUM_TASKS'(1) << idx_q) : '0;

  // Memory request mux: the active task's request passes through combinationally.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (task_selected) begin
      for (int i = 0; i < int'(NUM_TASKS); i++) begin
        if (idx_q == IDX_W'(i)) begin
          mem_we    = task_we[i];
          mem_addr  = task_addr[i*ADDR_W +: ADDR_W];
          mem_wdata = task_wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_task_sequencer.sv
// Testbench for task_sequencer. A task-list reference model steps alongside
// the DUT: directed scenarios first, then randomized traffic with occasional
// asynchronous resets.
module tb_task_sequencer;

  localparam int unsigned NT = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start, abort;
  logic [NT-1:0]     task_enable, task_finish, task_we;
  logic [NT*AW-1:0]  task_addr;
  logic [NT*DW-1:0]  task_wdata;
  logic [NT-1:0]     task_start;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              busy;
  logic [2:0]        active_task;
  logic              done;
  logic              error;

  task_sequencer #(
    .NUM_TASKS(NT), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .task_enable(task_enable), .task_finish(task_finish), .task_we(task_we),
    .task_addr(task_addr), .task_wdata(task_wdata), .task_start(task_start),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .active_task(active_task), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the list of tasks still to run plus what is happening now.
  bit m_idle = 1'b1, m_launch, m_wait, m_done, m_fail, m_err;
  int m_cur, m_waited;
  int m_pend[$];

  bit          hold_mem = 1'b0;
  logic [NT-1:0] started;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_launch = 1'b0; m_wait = 1'b0; m_done = 1'b0; m_fail = 1'b0;
    m_err = 1'b0; m_cur = 0; m_waited = 0;
    m_pend.delete();
  endtask

  // Advance the model over one clock edge given the inputs seen at that edge.
  task automatic model_advance(input bit st, input bit ab,
                               input logic [NT-1:0] en, input logic [NT-1:0] fin);
    if (m_done || m_fail) begin
      m_done = 1'b0; m_fail = 1'b0; m_idle = 1'b1;
    end else if (m_idle) begin
      if (st) begin
        m_err = 1'b0;
        m_pend.delete();
        for (int i = 0; i < int'(NT); i++) if (en[i]) m_pend.push_back(i);
        m_idle = 1'b0;
        if (m_pend.size() == 0) m_done = 1'b1;
        else begin m_cur = m_pend.pop_front(); m_launch = 1'b1; end
      end
    end else if (m_launch) begin
      m_launch = 1'b0;
      if (ab) begin m_fail = 1'b1; m_err = 1'b1; end
      else begin m_wait = 1'b1; m_waited = 0; end
    end else if (m_wait) begin
      m_waited++;
      if (ab) begin
        m_wait = 1'b0; m_fail = 1'b1; m_err = 1'b1;
      end else if (fin[m_cur]) begin
        m_wait = 1'b0;
        if (m_pend.size() != 0) begin m_cur = m_pend.pop_front(); m_launch = 1'b1; end
        else m_done = 1'b1;
      end else if (m_waited == int'(TO)) begin
        m_wait = 1'b0; m_fail = 1'b1; m_err = 1'b1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    bit            sel;
    logic [NT-1:0] exp_start;
    sel       = m_launch || m_wait;
    exp_start = m_launch ? (NT'(1) << m_cur) : '0;
    started   = started | task_start;
    check_eq({tag, ".busy"},   32'(busy),        32'(!m_idle));
    check_eq({tag, ".done"},   32'(done),        32'(m_done));
    check_eq({tag, ".error"},  32'(error),       32'(m_err));
    check_eq({tag, ".active"}, 32'(active_task), sel ? 32'(m_cur) : 32'd0);
    check_eq({tag, ".tstart"}, 32'(task_start),  32'(exp_start));
    check_eq({tag, ".mem_we"}, 32'(mem_we),      sel ? 32'(task_we[m_cur]) : 32'd0);
    check_eq({tag, ".mem_addr"}, 32'(mem_addr),  sel ? 32'(task_addr[m_cur*AW +: AW]) : 32'd0);
    check_eq({tag, ".mem_wdata"}, 32'(mem_wdata), sel ? 32'(task_wdata[m_cur*DW +: DW]) : 32'd0);
  endtask

  // One clock cycle: drive inputs, compare, advance model, move past the edge.
  task automatic step(input string tag, input bit st, input bit ab,
                      input logic [NT-1:0] en, input logic [NT-1:0] fin);
    start = st; abort = ab; task_enable = en; task_finish = fin;
    if (!hold_mem) begin
      task_we    = NT'($urandom);
      task_addr  = {$urandom};
      task_wdata = {$urandom};
    end
    #2;
    compare_all(tag);
    model_advance(st, ab, en, fin);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, 1'b0, 1'b0, '0, '0);
  endtask

  // Asynchronous reset pulse taken mid-cycle; outputs must clear at once.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    model_reset();
    #2;
    compare_all(tag);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    task_enable = '0; task_finish = '0; task_we = '0; task_addr = '0; task_wdata = '0;
    started = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    reset_n = 1'b1;

    // Two tasks, task 0 finishes 5 cycles after its start pulse.
    step("two.start", 1'b1, 1'b0, 4'b0011, '0);
    step("two.launch0", 1'b0, 1'b0, '0, '0);
    idle_steps("two.wait0", 4);
    step("two.fin0", 1'b0, 1'b0, '0, 4'b0001);
    step("two.launch1", 1'b0, 1'b0, '0, '0);
    step("two.fin1", 1'b0, 1'b0, '0, 4'b0010);
    idle_steps("two.tail", 2);

    // Sparse mask with a stray finish on a task that is not running.
    started = '0;
    step("sparse.start", 1'b1, 1'b0, 4'b1010, '0);
    step("sparse.launch1", 1'b0, 1'b0, '0, 4'b0100);
    step("sparse.stray", 1'b0, 1'b0, '0, 4'b0100);
    step("sparse.fin1", 1'b0, 1'b0, '0, 4'b0010);
    step("sparse.launch3", 1'b0, 1'b0, '0, 4'b0100);
    step("sparse.fin3", 1'b0, 1'b0, '0, 4'b1000);
    idle_steps("sparse.tail", 2);
    check_eq("sparse.started", 32'(started), 32'h0000000a);

    // Empty mask goes straight to a done pulse.
    started = '0;
    step("empty.start", 1'b1, 1'b0, 4'b0000, '0);
    idle_steps("empty.tail", 3);
    check_eq("empty.started", 32'(started), 32'd0);

    // Timeout: task never finishes; error held until the next start.
    step("tmo.start", 1'b1, 1'b0, 4'b0001, '0);
    idle_steps("tmo.wait", 12);
    check_eq("tmo.err_held", 32'(error), 32'd1);
    step("tmo.restart", 1'b1, 1'b0, 4'b0000, '0);
    idle_steps("tmo.tail", 2);

    // Abort and finish in the same WAIT cycle: abort wins.
    started = '0;
    step("abort.start", 1'b1, 1'b0, 4'b0011, '0);
    idle_steps("abort.wait", 3);
    step("abort.hit", 1'b0, 1'b1, '0, 4'b0001);
    idle_steps("abort.tail", 4);
    check_eq("abort.started", 32'(started), 32'h00000001);
    check_eq("abort.err", 32'(error), 32'd1);

    // Reset during WAIT of task 1 while it requests a write to 0x3C.
    step("rst.start", 1'b1, 1'b0, 4'b0011, '0);
    step("rst.launch0", 1'b0, 1'b0, '0, '0);
    step("rst.fin0", 1'b0, 1'b0, '0, 4'b0001);
    hold_mem   = 1'b1;
    task_we    = 4'b0010;
    task_addr  = 32'h00003C00;
    task_wdata = 32'h0000A500;
    step("rst.launch1", 1'b0, 1'b0, '0, '0);
    step("rst.wait1", 1'b0, 1'b0, '0, '0);
    check_eq("rst.pre_addr", 32'(mem_addr), 32'h3c);
    do_reset("rst.async");
    hold_mem = 1'b0;
    step("rst.restart", 1'b1, 1'b0, 4'b0011, '0);
    step("rst.relaunch", 1'b0, 1'b0, '0, '0);
    idle_steps("rst.tail", 2);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset("rnd.reset");
      else step("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
                NT'($urandom), NT'($urandom & $urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
